// File: rtl/truth_table_pkg.sv
// Shared types and constants for the truth-table sweeper.
// The sweeper drives all eight rows of a 3-input gate and rebuilds
// its 8-bit function word in gate-naming order (row 000 -> bit 7).
package truth_table_pkg;

  // Sweep controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } tt_state_t;

  // Number of input combinations of a 3-input gate.
  localparam int TT_ROWS = 8;

  // Function word of the m0xF8 gate.
  localparam logic [7:0] TT_DEFAULT_EXPECTED = 8'hF8;

  // Row idx lands in table bit 7-idx, so row 000 is the MSB.
  function automatic logic [2:0] tt_bit_index(input logic [2:0] idx);
    return 3'd7 - idx;
  endfunction

endpackage

// File: rtl/tt_sync2.sv
// Two-flop synchronizer for a single-bit asynchronous or off-chip signal.
// Synchronous active-high reset clears both stages to 0.
module tt_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops give metastability a full cycle to resolve.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: drives in1/in2/in3 through rows 000..111, holds each
// row for DWELL cycles, captures the gate output at the end of each dwell,
// and compares the assembled word with EXPECTED.
//
// Build option: define TT_SYNC_EN to route gate_out through a two-flop
// synchronizer (adds one cycle of sample latency, needs DWELL >= 4).
// Without it a single capture register is used (needs DWELL >= 2).
//
// Start/done handshake: start is a request sampled only while idle (busy=0,
// done=0); it is ignored in DRIVE and DONE and never queued. done is a
// single-cycle pulse; table_q, mismatch and match stay valid from that
// pulse until the next accepted start or reset.
module truth_table_sweeper
  import truth_table_pkg::*;
#(
  parameter int         DWELL    = 16,
  parameter logic [7:0] EXPECTED = TT_DEFAULT_EXPECTED
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       gate_out,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_q,
  output logic [7:0] mismatch,
  output logic       match,
  output logic [1:0] dbg_state
);

  localparam int             CW       = $clog2(DWELL);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DWELL - 1);

  tt_state_t     state;
  tt_state_t     state_nx;
  logic [2:0]    idx;
  logic [CW-1:0] cnt;
  logic          sample;
  logic          capture;
  logic          last_row;
  logic          res_valid;

  // ---------------------------------------------------------------------
  // Gate sample path
  // ---------------------------------------------------------------------
`ifdef TT_SYNC_EN
  if (DWELL < 4) begin : g_bad_dwell
    $error("truth_table_sweeper: DWELL must be >= 4 with the synchronizer");
  end

  tt_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (gate_out),
    .q   (sample)
  );
`else
  if (DWELL < 2) begin : g_bad_dwell
    $error("truth_table_sweeper: DWELL must be >= 2");
  end

  // Single capture register: the value used at the capture cycle is the
  // gate output seen one cycle earlier.
  always_ff @(posedge clk) begin
    if (rst) sample <= 1'b0;
    else     sample <= gate_out;
  end
`endif

  // The last dwell cycle of a row is the capture cycle.
  assign capture  = (state == DRIVE) && (cnt == CNT_LAST);
  assign last_row = capture && (idx == 3'(TT_ROWS - 1));

  // ---------------------------------------------------------------------
  // Controller
  // ---------------------------------------------------------------------

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic: one sweep per accepted start, DONE lasts one cycle.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start)    state_nx = DRIVE;
      DRIVE:   if (last_row) state_nx = DONE;
      DONE:                  state_nx = IDLE;
      default:               state_nx = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    busy      = (state == DRIVE);
    done      = (state == DONE);
    dbg_state = state;
  end

  // ---------------------------------------------------------------------
  // Datapath: row index, dwell counter, gate drive and table capture
  // ---------------------------------------------------------------------

  // Row/dwell bookkeeping; gate inputs are registered so they only move on
  // row boundaries and cannot glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx             <= '0;
      cnt             <= '0;
      {in1, in2, in3} <= 3'b000;
      table_q         <= '0;
      res_valid       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx             <= '0;
            cnt             <= '0;
            {in1, in2, in3} <= 3'b000;
            table_q         <= '0;
            res_valid       <= 1'b0;
          end
        end
        DRIVE: begin
          if (capture) begin
            table_q[tt_bit_index(idx)] <= sample;
            cnt                        <= '0;
            if (last_row) begin
              // Sweep ends here: park inputs at 000 and publish the result.
              idx             <= '0;
              {in1, in2, in3} <= 3'b000;
              res_valid       <= 1'b1;
            end else begin
              idx             <= idx + 3'd1;
              {in1, in2, in3} <= idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          {in1, in2, in3} <= 3'b000;
        end
        default: begin
          idx             <= '0;
          cnt             <= '0;
          {in1, in2, in3} <= 3'b000;
        end
      endcase
    end
  end

  // Comparison result is only meaningful once a full table has been built.
  always_comb begin
    mismatch = res_valid ? (table_q ^ EXPECTED) : 8'h00;
    match    = res_valid && (table_q == EXPECTED);
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper (default build, DWELL=16, EXPECTED=8'hF8).
// The gate under test is modelled by a function word: gate_out is the bit
// of gate_word selected by the driven row, row 000 in bit 7.
module tb_truth_table_sweeper;

  localparam int D     = 16;
  localparam int SWEEP = 8 * D;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       gate_out;
  logic       in1, in2, in3;
  logic       busy, done, match;
  logic [7:0] table_q, mismatch;
  logic [1:0] dbg_state;

  logic [7:0] gate_word;
  logic [2:0] drv;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] word;
    logic [7:0] exp_table;
    logic [7:0] exp_mis;
    logic       exp_match;
    logic       noisy;
  } vec_t;

  vec_t vecs[6];

  truth_table_sweeper #(.DWELL(D), .EXPECTED(8'hF8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .gate_out  (gate_out),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .busy      (busy),
    .done      (done),
    .table_q   (table_q),
    .mismatch  (mismatch),
    .match     (match),
    .dbg_state (dbg_state)
  );

  // Clock and gate model
  always #5 clk = ~clk;
  assign drv      = {in1, in2, in3};
  assign gate_out = gate_word[3'd7 - drv];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: pop the expected table on each done pulse.
  task automatic sb_on_done();
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      chk("sb_unexpected_done", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("sb_table", 32'(table_q), 32'(e));
    end
  endtask

  // One sweep from a start pulse; checks every cycle of drive and the result.
  // Sample point k is the falling edge after rising edge E0+k.
  task automatic run_sweep(input vec_t v);
    int done_cnt;
    logic exp_busy;
    logic exp_done;
    logic [2:0] exp_in;
    done_cnt  = 0;
    gate_word = v.word;
    exp_q.push_back(v.exp_table);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k <= SWEEP + 2; k++) begin
      exp_busy = (k < SWEEP);
      exp_done = (k == SWEEP);
      exp_in   = (k < SWEEP) ? 3'(k / D) : 3'b000;
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("done", 32'(done), 32'(exp_done));
      chk("in", 32'(drv), 32'(exp_in));
      if (done) begin
        done_cnt++;
        sb_on_done();
        chk("mismatch_at_done", 32'(mismatch), 32'(v.exp_mis));
        chk("match_at_done", 32'(match), 32'(v.exp_match));
      end
      start = (v.noisy && k < SWEEP - 1 && (k % 5) == 0) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("table_held", 32'(table_q), 32'(v.exp_table));
    chk("mismatch_held", 32'(mismatch), 32'(v.exp_mis));
    chk("match_held", 32'(match), 32'(v.exp_match));
  endtask

  initial begin
    int done_cnt;
    logic exp_busy;
    logic exp_done;

    vecs[0] = '{8'hF8, 8'hF8, 8'h00, 1'b1, 1'b0};
    vecs[1] = '{8'hFF, 8'hFF, 8'h07, 1'b0, 1'b0};
    vecs[2] = '{8'h00, 8'h00, 8'hF8, 1'b0, 1'b0};
    vecs[3] = '{8'h96, 8'h96, 8'h6E, 1'b0, 1'b1};
    vecs[4] = '{8'h7F, 8'h7F, 8'h87, 1'b0, 1'b0};
    vecs[5] = '{8'hF8, 8'hF8, 8'h00, 1'b1, 1'b1};

    // Reset
    rst       = 1'b1;
    start     = 1'b0;
    gate_word = 8'hF8;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_table", 32'(table_q), 32'd0);
    chk("rst_mismatch", 32'(mismatch), 32'd0);
    chk("rst_match", 32'(match), 32'd0);
    chk("rst_in", 32'(drv), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);

    // Table-driven sweeps
    for (int i = 0; i < 6; i++) run_sweep(vecs[i]);

    // Reset in the middle of row 4 (match is 1 from the previous sweep)
    gate_word = 8'hF8;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4 * D + 3) @(negedge clk);
    chk("pre_rst_row", 32'(drv), 32'd4);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_table", 32'(table_q), 32'd0);
    chk("mid_rst_in", 32'(drv), 32'd0);
    chk("mid_rst_match", 32'(match), 32'd0);
    chk("mid_rst_mismatch", 32'(mismatch), 32'd0);
    chk("mid_rst_state", 32'(dbg_state), 32'd0);
    done_cnt = 0;
    for (int k = 0; k < 2 * SWEEP; k++) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    chk("mid_rst_no_done", 32'(done_cnt), 32'd0);
    chk("mid_rst_idle_busy", 32'(busy), 32'd0);
    run_sweep(vecs[0]);

    // start held high: back-to-back sweeps, one idle cycle between them
    gate_word = 8'hF8;
    exp_q.push_back(8'hF8);
    exp_q.push_back(8'hF8);
    done_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k <= 2 * SWEEP + 6; k++) begin
      exp_busy = (k < SWEEP) || (k >= SWEEP + 2 && k < 2 * SWEEP + 2);
      exp_done = (k == SWEEP) || (k == 2 * SWEEP + 2);
      chk("b2b_busy", 32'(busy), 32'(exp_busy));
      chk("b2b_done", 32'(done), 32'(exp_done));
      if (done) begin
        done_cnt++;
        sb_on_done();
        chk("b2b_match", 32'(match), 32'd1);
      end
      if (k == 2 * SWEEP + 2) start = 1'b0;
      @(negedge clk);
    end
    chk("b2b_done_count", 32'(done_cnt), 32'd2);

    // Every pushed expectation must have been consumed
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    exp_q.delete();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Stimulus-and-capture stage wrapped around a 3-input logic gate such as m0xF8. It sits directly upstream of the gate, driving `in1`/`in2`/`in3`, and directly downstream, sampling `out`. On each `start` it sweeps all eight input combinations, holds each one for a settling dwell, and assembles the measured 8-bit truth table in the gate-naming bit order. It then flags any mismatch against the expected function word.

## Interface
- `DWELL`, default 16: cycles each input combination is held (≥2; ≥4 when `TT_SYNC_EN` is defined)
- `EXPECTED`, default 8'hF8: expected truth-table word
- `clk` input 1: single clock, rising edge
- `rst` input 1: reset, synchronous, active-high
- `start` input 1: begin a sweep; sampled only in IDLE
- `gate_out` input 1: output of the gate under test
- `in1`, `in2`, `in3` output 1 each: drive to the gate under test
- `busy` output 1: high throughout the sweep
- `done` output 1: one-cycle pulse when the table is complete
- `table_q` output 8: measured truth table, held until the next sweep starts
- `mismatch` output 8: `table_q ^ EXPECTED`, valid while `done` is high and afterwards
- `match` output 1: high when `mismatch == 0`, qualified as for `mismatch`

## Operation
- States: IDLE, DRIVE, DONE.
- IDLE → DRIVE when `start == 1`:
  - `idx` ← 0 and `cnt` ← 0.
  - `table_q` is cleared to 0.
  - `match` is cleared to 0.
- DRIVE behaviour:
  - `{in1,in2,in3} = idx`, with `in1` as the MSB.
  - `cnt` increments every cycle.
  - When `cnt == DWELL-1`, the sampled gate value is written to bit `table_q[7-idx]`. This places row 000 in bit 7, so the expected result for m0xF8 is 8'hF8.
  - On that same cycle `cnt` ← 0 and `idx` ← `idx+1`.
- DRIVE → DONE on the capture cycle for `idx == 7`. `idx` does not wrap into a second sweep.
- DONE state:
  - `done` = 1 for exactly one cycle.
  - `mismatch` and `match` update from the final `table_q`.
  - Inputs return to 000.
- DONE → IDLE unconditionally.
- `start` is ignored in DRIVE and DONE; no queuing.
- `start` held high continuously: a new sweep begins on the first IDLE cycle after DONE.
- Reset (any state, mid-sweep included), applied on the next edge:
  - State → IDLE; `idx`, `cnt` → 0.
  - `in1`/`in2`/`in3` → 0.
  - `busy`, `done`, `match` → 0.
  - `table_q`, `mismatch` → 0.
  - No partial table is retained.
- The value sampled is registered `gate_out`, or the synchronizer output when `TT_SYNC_EN` is defined.

## Timing
- `start` high at edge E0 → `busy`=1 and inputs=000 from E0+1.
- Each combination is driven for exactly `DWELL` cycles, so `busy` is high for 8·`DWELL` cycles.
- `done` is high for the cycle following the last capture, i.e. `DWELL`·8+1 cycles after E0. `busy` is 0 in that cycle.
- Sample latency:
  - Without `TT_SYNC_EN`: 1 cycle, so the value captured reflects `gate_out` at cycle `cnt == DWELL-2`.
  - With `TT_SYNC_EN`: 2 cycles.
- Inputs change only on combination boundaries and are glitch-free (registered).

## Configuration
- `TT_SYNC_EN` defined:
  - `gate_out` passes through a two-flop synchronizer before sampling, for asynchronous or off-chip gate outputs.
  - Capture timing shifts by one cycle as stated above.
  - `DWELL` < 4 is a elaboration error.
- `TT_SYNC_EN` undefined:
  - A single capture register only.
  - `DWELL` < 2 is an elaboration error.

## Structure
- Package `truth_table_pkg` holds:
  - State enum type `tt_state_t` (IDLE, DRIVE, DONE).
  - `TT_ROWS` = 8.
  - `TT_DEFAULT_EXPECTED` = 8'hF8.
  - Function `tt_bit_index(idx)` returning `7-idx`.
- One sub-module: `tt_sync2`, the 2-flop synchronizer with synchronous active-high reset to 0. It is instantiated only under `TT_SYNC_EN`.

## Test plan
- Gate model m0xF8 with `DWELL`=16:
  - Pulse `start` → `in` sequence 000…111, each held for 16 cycles.
  - `done` at cycle 129 after the start edge.
  - `table_q`=8'hF8, `match`=1, `mismatch`=0.
- Gate model stuck at 1 → `table_q`=8'hFF, `mismatch`=8'h07, `match`=0.
- Assert `rst` during row 4 → next cycle:
  - `busy`=0, `table_q`=0, `in`=000.
  - No `done` pulse.
  - A following `start` completes normally with 8'hF8.
- `start` pulsed repeatedly during a sweep → no restart, single `done`, total duration unchanged.
- `start` held high → back-to-back sweeps with one IDLE cycle between each `done` and the next `busy`.
- With `TT_SYNC_EN`: gate output delayed by 1 cycle → still 8'hF8 at `DWELL`=4. `DWELL`=3 fails elaboration.
